mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported, variable-latency unified memory between the pipeline's instruction-fetch port and its MEM-stage load/store port.
- One transaction is outstanding at a time.
- Data-side priority, with a starvation guard for fetch.
- Generates per-port stall signals for the hazard logic (PC hold, IF/ID keep, pipeline freeze).

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports.
- MAX_DATA_STREAK, 4, consecutive data grants allowed while fetch is waiting before fetch is forced to win (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held with if_addr until if_ready.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  fetch data; valid when if_ready=1.
- if_ready  out  1  one-cycle completion pulse for fetch.
- dm_req  in  1  data request; held with dm_we/dm_addr/dm_wdata until dm_ready.
- dm_we  in  1  1=store, 0=load.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  store data.
- dm_rdata  out  DATA_W  load data; valid when dm_ready=1.
- dm_ready  out  1  one-cycle completion pulse for data.
- stall_if  out  1  if_req & ~if_ready (combinational).
- stall_mem  out  1  dm_req & ~dm_ready (combinational).
- mem_req  out  1  memory request; held until mem_gnt.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_gnt  in  1  memory accepted request.
- mem_valid  in  1  response/ack pulse, earliest one cycle after mem_gnt; asserted for stores too.
- mem_rdata  in  DATA_W  response data, valid with mem_valid.

Behaviour:
- Reset (reset=0, async): state=IDLE, owner=NONE, streak=0. All outputs 0, including rdata registers and perf counters.
- FSM states:
  - IDLE: arbitrate.
    - dm_req only -> owner=DM.
    - if_req only -> owner=IF.
    - Both -> DM, unless streak==MAX_DATA_STREAK, then IF.
    - Latch the winner's we/addr/wdata into registers; go to REQ. No request -> stay in IDLE.
  - REQ: mem_req=1 with latched fields, stable until mem_gnt=1 -> WAIT.
  - WAIT: mem_req=0. On mem_valid, register mem_rdata into the owner's rdata register -> RESP.
  - RESP: owner's ready=1 for exactly one cycle -> IDLE.
- Latency: request seen in IDLE at cycle 0; mem_req at cycle 1. With gnt at cycle 1 and valid at cycle 2, ready is at cycle 3. Minimum 4 cycles per transaction including the IDLE arbitration cycle.
- Stores: mem_we=1. Returned mem_rdata is ignored and dm_rdata keeps its previous value.
- rdata registers hold their value until overwritten by the next load/fetch for that port.
- Streak counter, updated at each grant in IDLE:
  - DM grant with if_req=1 -> streak+1, saturating at MAX_DATA_STREAK.
  - DM grant with if_req=0 -> streak=0.
  - IF grant -> streak=0.
- A requester dropping req mid-transaction does not abort it. The memory cycle completes and ready still pulses.
- req still high in the IDLE cycle after RESP is a new transaction.
- mem_valid outside WAIT and mem_gnt outside REQ are ignored.
- Reset mid-transaction forces IDLE immediately. The memory side shares the same reset, so no abandoned-response handling is needed.
- Width: all address/data paths pass through unmodified. No alignment checks.

Optional Feature:
- Macro MEM_ARB_PERF_CNT_EN.
- Defined: adds outputs perf_if_grants, perf_dm_grants and perf_wait_cycles (32 bits each, wrap on overflow).
  - perf_if_grants and perf_dm_grants increment per grant.
  - perf_wait_cycles counts cycles with stall_if|stall_mem=1.
  - All three clear on reset.
- Undefined: the ports still exist and are tied to 0; no counter flops are generated.

Decomposition:
- Package mem_arb_pkg holds:
  - state encoding constants: IDLE=2'd0, REQ=2'd1, WAIT=2'd2, RESP=2'd3;
  - owner encoding: NONE=2'd0, IF=2'd1, DM=2'd2;
  - the default MAX_DATA_STREAK.
- One sub-module, mem_arb_streak_ctr: a saturating counter with inputs grant_dm, grant_if, if_pending, and output force_if.

Test Plan:
- Lone fetch: if_req=1, addr=0x40, mem_gnt on cycle 1, mem_valid with rdata=0x2002000A on cycle 2 -> if_ready=1 at cycle 3 with if_rdata=0x2002000A. stall_if=1 during cycles 0-2.
- Simultaneous req (fetch 0x44, store 0x100 data 0x55): data wins first (mem_we=1, mem_addr=0x100). Fetch is granted next, and dm_rdata is unchanged by the store.
- Starvation guard, MAX_DATA_STREAK=4, both held high continuously: the grant order is DM,DM,DM,DM,IF,DM..., and the streak returns to 0 after the IF grant.
- mem_gnt delayed 5 cycles in REQ: mem_req, mem_addr and mem_we stay stable throughout. A mem_valid pulse injected in REQ is ignored.
- reset driven low during WAIT, then released: all outputs are 0 immediately, state is IDLE, and a new dm load at 0x8 completes normally.
- With MEM_ARB_PERF_CNT_EN: after 3 fetches and 2 loads at minimum latency, perf_if_grants=3 and perf_dm_grants=2.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared encodings and defaults for the memory port arbiter.
//   arb_state_e   : arbiter FSM state encoding (IDLE/REQ/WAIT/RESP)
//   arb_owner_e   : owner of the outstanding memory transaction (NONE/IF/DM)
//   DEF_MAX_DATA_STREAK : default data-grant streak before fetch is forced
//   PERF_W        : width of the optional performance counters
//   cnt_width()   : bits needed to hold 0..max_val (at least 1)
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } arb_state_e;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        IF   = 2'd1,
        DM   = 2'd2
    } arb_owner_e;

    localparam int unsigned DEF_MAX_DATA_STREAK = 4;
    localparam int unsigned PERF_W              = 32;

    // Width of a counter that must reach max_val inclusive.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        int unsigned w;
        w = $clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mem_arb_streak_ctr.sv
// mem_arb_streak_ctr: counts consecutive data grants made while fetch waits.
//   clk, reset    : clock, async active-low reset
//   grant_dm      : data port granted this cycle
//   grant_if      : fetch port granted this cycle
//   if_pending    : fetch request present at the time of the grant
//   force_if      : streak has reached MAX_DATA_STREAK; fetch must win next
module mem_arb_streak_ctr
    import mem_arb_pkg::*;
#(
    parameter int unsigned MAX_DATA_STREAK = DEF_MAX_DATA_STREAK
) (
    input  logic clk,
    input  logic reset,
    input  logic grant_dm,
    input  logic grant_if,
    input  logic if_pending,
    output logic force_if
);

    localparam int unsigned         CNT_W   = cnt_width(MAX_DATA_STREAK);
    localparam logic [CNT_W-1:0]    MAX_CNT = CNT_W'(MAX_DATA_STREAK);

    logic [CNT_W-1:0] streak_q;
    logic [CNT_W-1:0] streak_d;

    // Saturating streak; any fetch grant or an uncontested data grant clears it.
    always_comb begin
        streak_d = streak_q;
        if (grant_if) begin
            streak_d = '0;
        end else if (grant_dm) begin
            if (!if_pending) begin
                streak_d = '0;
            end else if (streak_q != MAX_CNT) begin
                streak_d = streak_q + CNT_W'(1);
            end
        end
    end

    // force_if is registered from the next-state so it lines up with streak_q.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            streak_q <= '0;
            force_if <= 1'b0;
        end else begin
            streak_q <= streak_d;
            force_if <= (streak_d == MAX_CNT);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported, variable-latency memory between
// the instruction-fetch port (if_*) and the MEM-stage load/store port (dm_*).
// One transaction outstanding; data has priority, with a streak guard that
// forces a waiting fetch through after MAX_DATA_STREAK data grants.
//   clk, reset             : clock, async active-low reset
//   if_req/if_addr         : fetch request (held until if_ready)
//   if_rdata/if_ready      : fetch data, one-cycle completion pulse
//   dm_req/we/addr/wdata   : data request (held until dm_ready)
//   dm_rdata/dm_ready      : load data, one-cycle completion pulse
//   stall_if/stall_mem     : combinational stalls for the hazard logic
//   mem_req/we/addr/wdata  : memory request, held until mem_gnt
//   mem_gnt/valid/rdata    : memory accept, response pulse, response data
//   perf_*                 : grant/wait counters, present only when
//                            MEM_ARB_PERF_CNT_EN is defined (else tied to 0)
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W          = 32,
    parameter int unsigned DATA_W          = 32,
    parameter int unsigned MAX_DATA_STREAK = DEF_MAX_DATA_STREAK
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ready,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_valid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [PERF_W-1:0] perf_if_grants,
    output logic [PERF_W-1:0] perf_dm_grants,
    output logic [PERF_W-1:0] perf_wait_cycles
);

    arb_state_e        state_q;
    arb_owner_e        owner_q;
    logic              mem_req_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] dm_rdata_q;
    logic              if_ready_q;
    logic              dm_ready_q;

    logic              force_if;
    logic              grant_dm;
    logic              grant_if;

    // Arbitration: only in IDLE; data wins unless the streak guard has tripped.
    always_comb begin
        grant_dm = 1'b0;
        grant_if = 1'b0;
        if (state_q == IDLE) begin
            if (dm_req && !(if_req && force_if)) begin
                grant_dm = 1'b1;
            end else if (if_req) begin
                grant_if = 1'b1;
            end
        end
    end

    mem_arb_streak_ctr #(
        .MAX_DATA_STREAK (MAX_DATA_STREAK)
    ) u_streak (
        .clk        (clk),
        .reset      (reset),
        .grant_dm   (grant_dm),
        .grant_if   (grant_if),
        .if_pending (if_req),
        .force_if   (force_if)
    );

    // Transaction FSM; request fields are latched at grant so the requester
    // may drop or change its inputs without disturbing the memory cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            owner_q    <= NONE;
            mem_req_q  <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            if_ready_q <= 1'b0;
            dm_ready_q <= 1'b0;
        end else begin
            if_ready_q <= 1'b0;
            dm_ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_dm) begin
                        owner_q   <= DM;
                        we_q      <= dm_we;
                        addr_q    <= dm_addr;
                        wdata_q   <= dm_wdata;
                        mem_req_q <= 1'b1;
                        state_q   <= REQ;
                    end else if (grant_if) begin
                        owner_q   <= IF;
                        we_q      <= 1'b0;
                        addr_q    <= if_addr;
                        wdata_q   <= '0;
                        mem_req_q <= 1'b1;
                        state_q   <= REQ;
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        mem_req_q <= 1'b0;
                        state_q   <= WAIT;
                    end
                end
                WAIT: begin
                    // Store responses carry no data; dm_rdata keeps the last load.
                    if (mem_valid) begin
                        if (owner_q == IF) begin
                            if_rdata_q <= mem_rdata;
                        end else if (owner_q == DM && !we_q) begin
                            dm_rdata_q <= mem_rdata;
                        end
                        if_ready_q <= (owner_q == IF);
                        dm_ready_q <= (owner_q == DM);
                        state_q    <= RESP;
                    end
                end
                RESP: begin
                    owner_q <= NONE;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign if_ready  = if_ready_q;
    assign dm_ready  = dm_ready_q;

    assign stall_if  = if_req & ~if_ready_q;
    assign stall_mem = dm_req & ~dm_ready_q;

`ifdef MEM_ARB_PERF_CNT_EN
    logic [PERF_W-1:0] perf_if_q;
    logic [PERF_W-1:0] perf_dm_q;
    logic [PERF_W-1:0] perf_wait_q;

    // Free-running wrap-around counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_if_q   <= '0;
            perf_dm_q   <= '0;
            perf_wait_q <= '0;
        end else begin
            if (grant_if) begin
                perf_if_q <= perf_if_q + PERF_W'(1);
            end
            if (grant_dm) begin
                perf_dm_q <= perf_dm_q + PERF_W'(1);
            end
            if (stall_if || stall_mem) begin
                perf_wait_q <= perf_wait_q + PERF_W'(1);
            end
        end
    end

    assign perf_if_grants   = perf_if_q;
    assign perf_dm_grants   = perf_dm_q;
    assign perf_wait_cycles = perf_wait_q;
`else
    assign perf_if_grants   = '0;
    assign perf_dm_grants   = '0;
    assign perf_wait_cycles = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter. A behavioural
// memory with programmable grant/response delay serves the DUT; requester
// models push expected read data when they raise a request and expected
// memory transactions are queued by each test in the order they must appear.
module tb_mem_port_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          clk;
    logic          reset;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_ready;
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [DW-1:0] dm_rdata;
    logic          dm_ready;
    logic          stall_if;
    logic          stall_mem;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_gnt;
    logic          mem_valid;
    logic [DW-1:0] mem_rdata;
    logic [31:0]   perf_if_grants;
    logic [31:0]   perf_dm_grants;
    logic [31:0]   perf_wait_cycles;

    mem_port_arbiter #(
        .ADDR_W          (AW),
        .DATA_W          (DW),
        .MAX_DATA_STREAK (4)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .if_req           (if_req),
        .if_addr          (if_addr),
        .if_rdata         (if_rdata),
        .if_ready         (if_ready),
        .dm_req           (dm_req),
        .dm_we            (dm_we),
        .dm_addr          (dm_addr),
        .dm_wdata         (dm_wdata),
        .dm_rdata         (dm_rdata),
        .dm_ready         (dm_ready),
        .stall_if         (stall_if),
        .stall_mem        (stall_mem),
        .mem_req          (mem_req),
        .mem_we           (mem_we),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_gnt          (mem_gnt),
        .mem_valid        (mem_valid),
        .mem_rdata        (mem_rdata),
        .perf_if_grants   (perf_if_grants),
        .perf_dm_grants   (perf_dm_grants),
        .perf_wait_cycles (perf_wait_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } txn_t;

    localparam logic [DW-1:0] STORE_JUNK = 32'hBAD0_5707;
    localparam logic [DW-1:0] STRAY_DATA = 32'hDEAD_BEEF;

    txn_t          dm_todo[$];
    txn_t          exp_mem[$];
    logic [AW-1:0] if_todo[$];
    logic [DW-1:0] if_exp[$];
    logic [DW-1:0] dm_exp[$];

    int            n_vec;
    int            n_err;
    int            cyc;
    int            if_issue, dm_issue, if_lat, dm_lat;
    logic [DW-1:0] dm_last;

    int            gnt_delay, valid_delay, gnt_wait, valid_cnt;
    bit            req_seen, stray_valid, stray_gnt;
    txn_t          snap;

    function automatic logic [DW-1:0] data_of(input logic [AW-1:0] a);
        if (a == 32'h40) return 32'h2002_000A;
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic add_fetch(input logic [AW-1:0] a);
        if_todo.push_back(a);
    endtask

    task automatic add_dm(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        txn_t t;
        t.we = we; t.addr = a; t.wdata = d;
        dm_todo.push_back(t);
    endtask

    task automatic exp_txn(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        txn_t t;
        t.we = we; t.addr = a; t.wdata = d;
        exp_mem.push_back(t);
    endtask

    // One clock: check completions, advance requesters, then the memory model.
    task automatic step();
        txn_t          t;
        logic [AW-1:0] a;
        @(posedge clk);
        #1;
        cyc++;
        if (if_ready) begin
            if (if_exp.size() == 0) chk_eq("if_ready_spurious", 32'(if_ready), 32'd0);
            else begin
                chk_eq("if_rdata", if_rdata, if_exp.pop_front());
                if_lat = cyc - if_issue;
            end
        end
        if (dm_ready) begin
            if (dm_exp.size() == 0) chk_eq("dm_ready_spurious", 32'(dm_ready), 32'd0);
            else begin
                chk_eq("dm_rdata", dm_rdata, dm_exp.pop_front());
                dm_lat = cyc - dm_issue;
            end
        end
        if (if_ready || !if_req) begin
            if (if_todo.size() > 0) begin
                a = if_todo.pop_front();
                if_req = 1'b1; if_addr = a;
                if_exp.push_back(data_of(a));
                if_issue = cyc;
            end else if_req = 1'b0;
        end
        if (dm_ready || !dm_req) begin
            if (dm_todo.size() > 0) begin
                t = dm_todo.pop_front();
                dm_req = 1'b1; dm_we = t.we; dm_addr = t.addr; dm_wdata = t.wdata;
                if (!t.we) dm_last = data_of(t.addr);
                dm_exp.push_back(dm_last);
                dm_issue = cyc;
            end else dm_req = 1'b0;
        end
        mem_gnt = 1'b0; mem_valid = 1'b0; mem_rdata = '0;
        if (valid_cnt > 0) begin
            valid_cnt--;
            if (valid_cnt == 0) begin
                mem_valid = 1'b1;
                mem_rdata = snap.we ? STORE_JUNK : data_of(snap.addr);
            end else if (stray_gnt) begin
                mem_gnt = 1'b1; stray_gnt = 1'b0;
            end
        end
        if (mem_req) begin
            if (!req_seen) begin
                req_seen = 1'b1; gnt_wait = gnt_delay;
                snap.we = mem_we; snap.addr = mem_addr; snap.wdata = mem_wdata;
                if (exp_mem.size() == 0) chk_eq("mem_req_unexpected", 32'(mem_req), 32'd0);
                else begin
                    t = exp_mem.pop_front();
                    chk_eq("mem_we", 32'(mem_we), 32'(t.we));
                    chk_eq("mem_addr", mem_addr, t.addr);
                    if (t.we) chk_eq("mem_wdata", mem_wdata, t.wdata);
                end
            end else begin
                chk_eq("hold_we", 32'(mem_we), 32'(snap.we));
                chk_eq("hold_addr", mem_addr, snap.addr);
                chk_eq("hold_wdata", mem_wdata, snap.wdata);
            end
            if (gnt_wait == 0) begin
                mem_gnt = 1'b1; req_seen = 1'b0; valid_cnt = valid_delay;
            end else begin
                gnt_wait--;
                if (stray_valid) begin
                    mem_valid = 1'b1; mem_rdata = STRAY_DATA; stray_valid = 1'b0;
                end
            end
        end
        #1;
        chk_eq("stall_if", 32'(stall_if), 32'(if_req & ~if_ready));
        chk_eq("stall_mem", 32'(stall_mem), 32'(dm_req & ~dm_ready));
    endtask

    function automatic bit tb_idle();
        return (if_todo.size() == 0) && (dm_todo.size() == 0) && (if_exp.size() == 0) &&
               (dm_exp.size() == 0) && (exp_mem.size() == 0) && !if_req && !dm_req &&
               (valid_cnt == 0) && !req_seen;
    endfunction

    task automatic run_until_idle(input int budget);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!tb_idle() && n < budget);
        chk_eq("drain", 32'(tb_idle()), 32'd1);
    endtask

    task automatic chk_reset_outputs();
        chk_eq("rst_if_rdata", if_rdata, 32'd0);
        chk_eq("rst_if_ready", 32'(if_ready), 32'd0);
        chk_eq("rst_dm_rdata", dm_rdata, 32'd0);
        chk_eq("rst_dm_ready", 32'(dm_ready), 32'd0);
        chk_eq("rst_stall_if", 32'(stall_if), 32'd0);
        chk_eq("rst_stall_mem", 32'(stall_mem), 32'd0);
        chk_eq("rst_mem_req", 32'(mem_req), 32'd0);
        chk_eq("rst_mem_we", 32'(mem_we), 32'd0);
        chk_eq("rst_mem_addr", mem_addr, 32'd0);
        chk_eq("rst_mem_wdata", mem_wdata, 32'd0);
        chk_eq("rst_perf_if", perf_if_grants, 32'd0);
        chk_eq("rst_perf_dm", perf_dm_grants, 32'd0);
        chk_eq("rst_perf_wait", perf_wait_cycles, 32'd0);
    endtask

    task automatic clear_model();
        if_todo.delete(); dm_todo.delete(); exp_mem.delete();
        if_exp.delete(); dm_exp.delete();
        valid_cnt = 0; gnt_wait = 0; req_seen = 1'b0;
        stray_valid = 1'b0; stray_gnt = 1'b0;
        if_req = 1'b0; dm_req = 1'b0;
        mem_gnt = 1'b0; mem_valid = 1'b0; mem_rdata = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        n_vec = 0; n_err = 0; cyc = 0;
        if_issue = 0; dm_issue = 0; if_lat = 0; dm_lat = 0; dm_last = '0;
        gnt_delay = 0; valid_delay = 1;
        reset = 1'b0;
        if_addr = '0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
        clear_model();

        #3;
        chk_reset_outputs();
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b1;

        // Lone fetch at minimum latency.
        add_fetch(32'h40); exp_txn(1'b0, 32'h40, '0);
        run_until_idle(50);
        chk_eq("lone_if_rdata", if_rdata, 32'h2002_000A);
        chk_eq("lone_if_lat", 32'(if_lat), 32'd3);

        // Load so dm_rdata holds a known nonzero value.
        add_dm(1'b0, 32'h60, '0); exp_txn(1'b0, 32'h60, '0);
        run_until_idle(50);
        chk_eq("load_dm_lat", 32'(dm_lat), 32'd3);

        // Simultaneous fetch + store: store first, load data untouched.
        add_fetch(32'h44); add_dm(1'b1, 32'h100, 32'h55);
        exp_txn(1'b1, 32'h100, 32'h55); exp_txn(1'b0, 32'h44, '0);
        run_until_idle(60);
        chk_eq("store_keeps_dm_rdata", dm_rdata, data_of(32'h60));

        // Starvation guard with both ports held busy.
        for (int i = 0; i < 10; i++) add_dm(1'b0, 32'h300 + 32'(4 * i), '0);
        add_fetch(32'h500); add_fetch(32'h504);
        for (int i = 0; i < 4; i++) exp_txn(1'b0, 32'h300 + 32'(4 * i), '0);
        exp_txn(1'b0, 32'h500, '0);
        for (int i = 4; i < 8; i++) exp_txn(1'b0, 32'h300 + 32'(4 * i), '0);
        exp_txn(1'b0, 32'h504, '0);
        for (int i = 8; i < 10; i++) exp_txn(1'b0, 32'h300 + 32'(4 * i), '0);
        run_until_idle(200);

        // Slow grant with stray valid in REQ and stray gnt in WAIT.
        gnt_delay = 5; valid_delay = 3;
        stray_valid = 1'b1; stray_gnt = 1'b1;
        add_dm(1'b1, 32'h124, 32'hA5A5_0F0F); exp_txn(1'b1, 32'h124, 32'hA5A5_0F0F);
        run_until_idle(60);
        stray_valid = 1'b1; stray_gnt = 1'b1;
        add_dm(1'b0, 32'h120, '0); exp_txn(1'b0, 32'h120, '0);
        run_until_idle(60);
        chk_eq("slow_dm_rdata", dm_rdata, data_of(32'h120));

        // Reset while the memory cycle is in WAIT.
        gnt_delay = 0; valid_delay = 4;
        add_dm(1'b0, 32'h200, '0); exp_txn(1'b0, 32'h200, '0);
        n = 0;
        while (valid_cnt == 0 && n < 20) begin
            step();
            n++;
        end
        step();
        chk_eq("reached_wait", 32'(valid_cnt > 0), 32'd1);
        #1;
        reset = 1'b0;
        clear_model();
        #1;
        chk_reset_outputs();
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        valid_delay = 1; dm_last = '0;
        add_dm(1'b0, 32'h8, '0); exp_txn(1'b0, 32'h8, '0);
        run_until_idle(50);
        chk_eq("post_rst_dm_rdata", dm_rdata, data_of(32'h8));
        chk_eq("post_rst_dm_lat", 32'(dm_lat), 32'd3);

        // Three fetches and one more load, one at a time, minimum latency.
        for (int i = 0; i < 3; i++) begin
            add_fetch(32'h600 + 32'(4 * i)); exp_txn(1'b0, 32'h600 + 32'(4 * i), '0);
            run_until_idle(50);
        end
        add_dm(1'b0, 32'h700, '0); exp_txn(1'b0, 32'h700, '0);
        run_until_idle(50);
`ifdef MEM_ARB_PERF_CNT_EN
        chk_eq("perf_if_grants", perf_if_grants, 32'd3);
        chk_eq("perf_dm_grants", perf_dm_grants, 32'd2);
        chk_eq("perf_wait_cycles", perf_wait_cycles, 32'd15);
`else
        chk_eq("perf_if_tied", perf_if_grants, 32'd0);
        chk_eq("perf_dm_tied", perf_dm_grants, 32'd0);
        chk_eq("perf_wait_tied", perf_wait_cycles, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
